instr_fetch_stage: RTL and testbench

- Upstream neighbour of the opcode decoder (control unit): owns the PC, fetches from instruction memory over a req/ready handshake, and holds the IF/ID pipeline register.
- Its `opcode` output feeds the decoder directly.
- Honours stalls from hazard logic and redirects from branch resolution (EX) and jump decode (ID), flushing the fetched instruction on redirect.

---
 rtl/mips_pkg.sv | 19 +
 rtl/instr_fetch_stage_if_id_reg.sv | 42 ++++
 rtl/instr_fetch_stage.sv | 120 ++++++++++++
 tb/tb_instr_fetch_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: opcodes, the NOP word and the
// fetch-state encoding used by the fetch stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // sll $0,$0,0 -- architecturally a no-op
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HELD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise holds its contents.
module if_id_reg #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [DATA_W-1:0] pc_plus4_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] pc_plus4_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] pc_plus4_q;
  logic              valid_q;

  // Register update: flush inserts a bubble, load captures a new instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (flush_i) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (load_i) begin
      instr_q    <= instr_i;
      pc_plus4_q <= pc_plus4_i;
      valid_q    <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, imem req/ready handshake, one-entry skid
// buffer for words that arrive during a stall, and the IF/ID register.
module instr_fetch_stage #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              jump,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_pc_plus4,
  output logic              if_id_valid,
  output logic [5:0]        opcode
);

  import mips_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [DATA_W-1:0] skid_pc4_q, skid_pc4_d;

  logic              load, flush, redirect;
  logic [DATA_W-1:0] pc_plus4, jump_target, redirect_target;
  logic [DATA_W-1:0] load_instr, load_pc4;

  assign pc_plus4    = pc_q + DATA_W'(4);
  // Jump only makes sense for a real instruction sitting in IF/ID
  assign jump_target = {if_id_pc_plus4[DATA_W-1:DATA_W-4], if_id_instr[25:0], 2'b00};
  assign redirect    = branch_taken | (jump & if_id_valid);
  // EX is older than ID, so a resolved branch beats a decoded jump
  assign redirect_target = branch_taken ? branch_target : jump_target;

  // Next-state, PC and IF/ID control; redirect overrides stall and ready
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    load         = 1'b0;
    flush        = 1'b0;
    load_instr   = imem_rdata;
    load_pc4     = pc_plus4;
    if (redirect) begin
      pc_d         = redirect_target;
      flush        = 1'b1;
      skid_instr_d = '0;
      skid_pc4_d   = '0;
      state_d      = FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            pc_d = pc_plus4;
            if (!stall) begin
              load = 1'b1;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc4_d   = pc_plus4;
              state_d      = HELD;
            end
          end
        end
        HELD: begin
          if (!stall) begin
            load       = 1'b1;
            load_instr = skid_instr_q;
            load_pc4   = skid_pc4_q;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State, PC and skid buffer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  // Request drops asynchronously with reset, not just at the next edge
  assign imem_req  = (state_q == FETCH) && !reset;
  assign imem_addr = pc_q;
  assign opcode    = if_id_instr[DATA_W-1:DATA_W-6];

  if_id_reg #(
    .DATA_W    (DATA_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .flush_i    (flush),
    .instr_i    (load_instr),
    .pc_plus4_i (load_pc4),
    .instr_o    (if_id_instr),
    .pc_plus4_o (if_id_pc_plus4),
    .valid_o    (if_id_valid)
  );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: scoreboard of expected IF/ID loads plus
// direct checks of PC/request behaviour around stalls, redirects and reset.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [5:0]  opcode;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t sbq[$];

  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc4   = '0;

  always #5 clk = ~clk;

  instr_fetch_stage #(
    .DATA_W    (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .opcode         (opcode)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h8C01_0004;
      32'h0000_0004: return 32'h0022_1820;
      32'h0000_1000: return 32'h0800_0010;
      default:       return {6'b101000, a[25:0]};
    endcase
  endfunction

  assign imem_rdata = memword(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc4);
    exp_t e;
    e.instr = instr;
    e.pc4   = pc4;
    sbq.push_back(e);
  endtask

  // A new IF/ID output is a valid rise or a change of pc_plus4 while valid
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (if_id_valid && (!prev_valid || if_id_pc_plus4 != prev_pc4)) begin
      check_eq("sb_avail", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check_eq("sb_instr", if_id_instr, e.instr);
        check_eq("sb_pc4", if_id_pc_plus4, e.pc4);
      end
    end
    prev_valid = if_id_valid;
    prev_pc4   = if_id_pc_plus4;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b1;
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(if_id_valid), 32'd0);
    check_eq("rst_instr", if_id_instr, 32'h0);
    check_eq("rst_pc4", if_id_pc_plus4, 32'h0);
    check_eq("rst_addr", imem_addr, 32'h0);

    @(negedge clk); reset = 1'b0; #1;
    check_eq("rel_req", 32'(imem_req), 32'd1);
    check_eq("rel_addr", imem_addr, 32'h0);

    // zero-wait streaming
    push_exp(32'h8C01_0004, 32'h4); tick();
    check_eq("op_lw", 32'(opcode), 32'h23);
    check_eq("addr4", imem_addr, 32'h4);
    push_exp(32'h0022_1820, 32'h8); tick();
    check_eq("op_r", 32'(opcode), 32'h0);
    check_eq("addr8", imem_addr, 32'h8);

    // stall while memory responds at pc=8 -> HELD
    stall = 1'b1; tick();
    check_eq("held_addr", imem_addr, 32'hC);
    check_eq("held_req", 32'(imem_req), 32'd0);
    check_eq("held_instr", if_id_instr, 32'h0022_1820);
    check_eq("held_pc4", if_id_pc_plus4, 32'h8);
    tick();
    check_eq("held2_addr", imem_addr, 32'hC);
    check_eq("held2_instr", if_id_instr, 32'h0022_1820);
    stall = 1'b0; push_exp(memword(32'h8), 32'hC); tick();
    check_eq("resume_addr", imem_addr, 32'hC);
    check_eq("resume_req", 32'(imem_req), 32'd1);
    push_exp(memword(32'hC), 32'h10); tick();
    check_eq("addr10", imem_addr, 32'h10);

    // memory not ready at 0x10, stall irrelevant
    imem_ready = 1'b0; stall = 1'b1; tick();
    check_eq("wait_req", 32'(imem_req), 32'd1);
    check_eq("wait_addr", imem_addr, 32'h10);
    check_eq("wait_instr", if_id_instr, memword(32'hC));
    stall = 1'b0; tick();
    check_eq("wait2_addr", imem_addr, 32'h10);
    reset = 1'b1; #1;
    check_eq("arst_req", 32'(imem_req), 32'd0);
    check_eq("arst_valid", 32'(if_id_valid), 32'd0);
    check_eq("arst_addr", imem_addr, 32'h0);
    @(negedge clk); reset = 1'b0; imem_ready = 1'b1;

    // branch with stall and ready in the same cycle
    push_exp(32'h8C01_0004, 32'h4); tick();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40; tick();
    check_eq("br_addr", imem_addr, 32'h40);
    check_eq("br_valid", 32'(if_id_valid), 32'd0);
    check_eq("br_instr", if_id_instr, 32'h0);
    check_eq("br_req", 32'(imem_req), 32'd1);
    branch_taken = 1'b0; stall = 1'b0;

    // jump with empty IF/ID is ignored
    imem_ready = 1'b0; jump = 1'b1; tick();
    check_eq("jinv_addr", imem_addr, 32'h40);
    jump = 1'b0;

    // jump from J at 0x1000
    branch_taken = 1'b1; branch_target = 32'h1000; tick();
    branch_taken = 1'b0; imem_ready = 1'b1;
    check_eq("br1000_addr", imem_addr, 32'h1000);
    push_exp(32'h0800_0010, 32'h1004); tick();
    check_eq("op_j", 32'(opcode), 32'h02);
    jump = 1'b1; tick(); jump = 1'b0;
    check_eq("j_addr", imem_addr, 32'h40);
    check_eq("j_valid", 32'(if_id_valid), 32'd0);
    check_eq("j_instr", if_id_instr, 32'h0);

    // branch beats jump
    branch_taken = 1'b1; branch_target = 32'h1000; tick(); branch_taken = 1'b0;
    push_exp(32'h0800_0010, 32'h1004); tick();
    jump = 1'b1; branch_taken = 1'b1; branch_target = 32'h80; tick();
    jump = 1'b0; branch_taken = 1'b0;
    check_eq("bj_addr", imem_addr, 32'h80);
    check_eq("bj_valid", 32'(if_id_valid), 32'd0);

    // PC wrap
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; tick(); branch_taken = 1'b0;
    check_eq("top_addr", imem_addr, 32'hFFFF_FFFC);
    push_exp(memword(32'hFFFF_FFFC), 32'h0); tick();
    check_eq("wrap_addr", imem_addr, 32'h0);
    check_eq("wrap_pc4", if_id_pc_plus4, 32'h0);

    // redirect while HELD drops the skid buffer
    stall = 1'b1; tick();
    check_eq("h2_req", 32'(imem_req), 32'd0);
    check_eq("h2_addr", imem_addr, 32'h4);
    branch_taken = 1'b1; branch_target = 32'h200; tick(); branch_taken = 1'b0;
    check_eq("hbr_addr", imem_addr, 32'h200);
    check_eq("hbr_req", 32'(imem_req), 32'd1);
    stall = 1'b0; imem_ready = 1'b0; tick();
    check_eq("skid_drop_valid", 32'(if_id_valid), 32'd0);
    check_eq("skid_drop_addr", imem_addr, 32'h200);

    check_eq("sb_left", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
